// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB,
// drives datapath strobes and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      INST,
  input  logic             BrTkn,
  input  logic             MEM_RDY,
  output logic [3:0]       ALU_OP,
  output logic [1:0]       ALU_SRC_A,
  output logic [1:0]       ALU_SRC_B,
  output logic             PC_WRITE,
  output logic             PC_SRC,
  output logic             IR_WRITE,
  output logic             IORD,
  output logic             MEM_READ,
  output logic             MEM_WRITE,
  output logic             REG_WRITE,
  output logic [1:0]       WB_SEL,
  output logic [2:0]       STATE,
  output logic             HALT,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  state_t state, next;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;
  logic       is_op, is_opi, is_ld, is_st, is_br;
  logic       is_jal, is_jalr, is_lui, is_auipc, legal;
  logic [3:0] alu_f;
  logic [3:0] br_op;
  logic       br_ok;
  logic       unused_bits;

  assign opc  = INST[6:0];
  assign f3   = INST[14:12];
  assign f7b5 = INST[30];
  assign unused_bits = ^{INST[31], INST[29:15], INST[11:7]};

  assign is_op    = opc == 7'b0110011;
  assign is_opi   = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign legal    = is_op | is_opi | is_ld | is_st | is_br |
                    is_jal | is_jalr | is_lui | is_auipc;

  // funct7[5] selects SUB only for register ops, SRA for both
  always_comb begin
    alu_f = 4'h0;
    unique case (f3)
      3'b000: alu_f = (is_op && f7b5) ? 4'h1 : 4'h0;
      3'b001: alu_f = 4'h9;
      3'b010: alu_f = 4'h2;
      3'b011: alu_f = 4'h4;
      3'b100: alu_f = 4'h6;
      3'b101: alu_f = f7b5 ? 4'hB : 4'hA;
      3'b110: alu_f = 4'h8;
      3'b111: alu_f = 4'h7;
      default: alu_f = 4'h0;
    endcase
  end

  always_comb begin
    br_op = 4'h0;
    br_ok = 1'b1;
    unique case (f3)
      3'b000: br_op = 4'hC;
      3'b001: br_op = 4'hD;
      3'b100: br_op = 4'h2;
      3'b101: br_op = 4'h3;
      3'b110: br_op = 4'h4;
      3'b111: br_op = 4'h5;
      default: br_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IF;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    ALU_OP    = 4'h0;
    ALU_SRC_A = 2'd0;
    ALU_SRC_B = 2'd0;
    PC_WRITE  = 1'b0;
    PC_SRC    = 1'b0;
    IR_WRITE  = 1'b0;
    IORD      = 1'b0;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    REG_WRITE = 1'b0;
    WB_SEL    = 2'd0;
    HALT      = 1'b0;
    if (!RST) begin
      unique case (state)
        S_IF: begin
          MEM_READ  = 1'b1;
          ALU_SRC_B = 2'd2;
          IR_WRITE  = MEM_RDY;
          PC_WRITE  = MEM_RDY;
          if (MEM_RDY) next = S_ID;
        end
        S_ID: begin
          ALU_SRC_A = 2'd1;
          ALU_SRC_B = 2'd1;
          next = legal ? S_EX : S_HALT;
        end
        S_EX: begin
          next = S_WB;
          unique case (1'b1)
            is_op: begin
              ALU_SRC_A = 2'd2;
              ALU_OP    = alu_f;
            end
            is_opi: begin
              ALU_SRC_A = 2'd2;
              ALU_SRC_B = 2'd1;
              ALU_OP    = alu_f;
            end
            is_ld, is_st: begin
              ALU_SRC_A = 2'd2;
              ALU_SRC_B = 2'd1;
              next = S_MEM;
            end
            is_lui: begin
              ALU_SRC_A = 2'd3;
              ALU_SRC_B = 2'd1;
            end
            is_auipc: begin
              ALU_SRC_A = 2'd1;
              ALU_SRC_B = 2'd1;
            end
            is_br: begin
              ALU_SRC_A = 2'd2;
              PC_SRC    = 1'b1;
              if (br_ok) begin
                ALU_OP   = br_op;
                PC_WRITE = BrTkn;
                next = S_IF;
              end else begin
                next = S_HALT;
              end
            end
            is_jal: begin
              PC_WRITE = 1'b1;
              PC_SRC   = 1'b1;
            end
            is_jalr: begin
              ALU_SRC_A = 2'd2;
              ALU_SRC_B = 2'd1;
              PC_WRITE  = 1'b1;
            end
            default: next = S_HALT;
          endcase
        end
        S_MEM: begin
          IORD      = 1'b1;
          MEM_READ  = is_ld;
          MEM_WRITE = is_st;
          if (MEM_RDY) next = is_ld ? S_WB : S_IF;
        end
        S_WB: begin
          REG_WRITE = 1'b1;
          if (is_ld)                WB_SEL = 2'd1;
          else if (is_jal | is_jalr) WB_SEL = 2'd2;
          next = S_IF;
        end
        S_HALT: HALT = 1'b1;
        default: next = S_HALT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      INSTR_CNT <= '0;
    else if (next == S_IF &&
             (state == S_EX || state == S_MEM || state == S_WB))
      INSTR_CNT <= INSTR_CNT + CNT_W'(1);
  end

  assign STATE = state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle RV32I core.
- Sequences each instruction through IF/ID/EX/MEM/WB.
- Drives the shared ALU opcode (4-bit encoding below), operand muxes, PC/IR/register-file/memory strobes; stalls on memory handshake.
- Keeps a retired-instruction counter; halts on an illegal opcode.

Parameters:
CNT_W, 32, width of retired-instruction counter INSTR_CNT.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
INST  in  32  instruction register contents from datapath; valid from ID onward.
BrTkn  in  1  ALU branch-taken flag, combinational, same cycle.
MEM_RDY  in  1  memory completes access this cycle.
ALU_OP  out  4  0 ADD, 1 SUB, 2 SLT, 3 SGE, 4 SLTU, 5 SGEU, 6 XOR, 7 AND, 8 OR, 9 SLL, A SRL, B SRA, C EQ, D NE.
ALU_SRC_A  out  2  0 PC, 1 OLDPC, 2 RS1, 3 ZERO.
ALU_SRC_B  out  2  0 RS2, 1 IMM, 2 const 4.
PC_WRITE  out  1  load PC.
PC_SRC  out  1  0 ALU result, 1 ALUOut register.
IR_WRITE  out  1  load IR and OLDPC<=PC.
IORD  out  1  0 address=PC, 1 address=ALUOut.
MEM_READ  out  1  memory read request.
MEM_WRITE  out  1  memory write request.
REG_WRITE  out  1  register-file write.
WB_SEL  out  2  0 ALUOut, 1 memory data, 2 PC.
STATE  out  3  0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 7 HALT.
HALT  out  1  high in HALT state.
INSTR_CNT  out  CNT_W  retired instructions.

Behaviour:
- Clock/reset: one clock CLK. RST asynchronous, active-high.
- While RST=1: STATE=0 (IF), INSTR_CNT=0, HALT=0, all strobes forced 0. The same holds when RST is asserted mid-instruction.
- Output decode: combinational from STATE and INST. PC_WRITE in EX also depends on BrTkn. Undriven selects are 0.
- Opcode classes (INST[6:0]): OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode is illegal.
- IF: MEM_READ=1, IORD=0, ALU_SRC_A=0, ALU_SRC_B=2, ALU_OP=0, PC_SRC=0, IR_WRITE=PC_WRITE=MEM_RDY. Stay in IF until MEM_RDY=1, then go to ID.
- ID: ALU_SRC_A=1, ALU_SRC_B=1, ALU_OP=0 (branch/JAL target into ALUOut).
  - Illegal opcode -> HALT.
  - Otherwise -> EX.
- EX, by class:
  - OP: SRC_A=2, SRC_B=0, opcode from funct3.
  - OP-IMM: as OP with SRC_B=1.
  - LOAD/STORE: SRC_A=2, SRC_B=1, ADD.
  - LUI: SRC_A=3, SRC_B=1, ADD.
  - AUIPC: SRC_A=1, SRC_B=1, ADD.
  - BRANCH: SRC_A=2, SRC_B=0, PC_SRC=1, PC_WRITE=BrTkn. Opcode from funct3: 000->C, 001->D, 100->2, 101->3, 110->4, 111->5; other funct3 -> HALT.
  - JAL: PC_WRITE=1, PC_SRC=1.
  - JALR: SRC_A=2, SRC_B=1, ADD, PC_WRITE=1, PC_SRC=0.
- funct3 decode for OP/OP-IMM:
  - 000: ADD; SUB only when OP and funct7[5]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRL; SRA when funct7[5]=1.
  - 110 OR, 111 AND.
- EX next state: BRANCH -> IF; LOAD/STORE -> MEM; all others -> WB.
- MEM: IORD=1, MEM_READ=1 (LOAD) or MEM_WRITE=1 (STORE), held while MEM_RDY=0.
  - On MEM_RDY=1: LOAD -> WB, STORE -> IF.
- WB: REG_WRITE=1. WB_SEL=1 for LOAD, 2 for JAL/JALR, 0 otherwise. Then -> IF.
- INSTR_CNT increments by 1 on every transition into IF from EX/MEM/WB. Wraps modulo 2^CNT_W.
- HALT: HALT=1, all strobes 0, ALU_OP=0. Exits only via RST.
- Latency with MEM_RDY=1: BRANCH 3 cycles; STORE, ALU ops, LUI/AUIPC, JAL/JALR 4; LOAD 5. Each cycle of MEM_RDY=0 in IF/MEM adds 1.

Test Plan:
1. ADD 0x002081B3, MEM_RDY=1 -> STATE 0,1,2,4,0. EX: ALU_OP=0, SRC_A=2, SRC_B=0. WB: REG_WRITE=1, WB_SEL=0. INSTR_CNT=1.
2. SUB 0x402081B3 -> EX ALU_OP=1. SRA 0x4020D1B3 -> EX ALU_OP=B. ADDI with funct7 bit set -> ALU_OP=0.
3. LW 0x0000A283, MEM_RDY low 3 cycles in MEM -> MEM_READ=1, IORD=1 for 4 cycles. Total 8 cycles. WB_SEL=1.
4. BNE 0x00209463: BrTkn=1 -> EX ALU_OP=D, PC_WRITE=1, PC_SRC=1, next IF after 3 cycles. BrTkn=0 -> PC_WRITE=0.
5. INST=0xFFFFFFFF -> HALT=1, STATE=7 cycle after ID. All strobes 0 for 10 cycles. INSTR_CNT unchanged.
6. RST pulsed during MEM of a store -> MEM_WRITE drops immediately. STATE=0, INSTR_CNT=0. Normal fetch resumes after release.
